// File: rtl/matrix_inv_if.sv
// Handshake and data bundle for matrix_inv: product vector in, recovered source vector out.
interface matrix_inv_if;
    localparam int unsigned MW = 10;
    localparam int unsigned DW = 4;

    logic          in_valid;
    logic          in_ready;
    logic [MW-1:0] mo0;
    logic [MW-1:0] mo1;
    logic [MW-1:0] mo2;
    logic          out_valid;
    logic [DW-1:0] di0;
    logic [DW-1:0] di1;
    logic [DW-1:0] di2;
    logic          exact;
    logic          busy;

    modport master (
        output in_valid, mo0, mo1, mo2,
        input  in_ready, out_valid, di0, di1, di2, exact, busy
    );

    modport slave (
        input  in_valid, mo0, mo1, mo2,
        output in_ready, out_valid, di0, di1, di2, exact, busy
    );
endinterface

// File: rtl/matrix_inv.sv
// Inverts the fixed (A,B,C)/(B,B,A)/(C,B,A) multiplier via adjugate multiply and a shared serial divider.
// Optional MATINV_CHECK_EN adds a forward-product check state before completion.
module matrix_inv #(
    parameter int          A  = 7,
    parameter int          B  = 13,
    parameter int          C  = 5,
    parameter int unsigned NW = 20
) (
    input  logic        clk,
    input  logic        rst,
    matrix_inv_if.slave bus
);
    localparam int unsigned MW  = 10;
    localparam int unsigned DW  = 4;
    localparam int unsigned SW  = NW + 1;
    localparam int unsigned RW  = NW + 1;
    localparam int unsigned STW = $clog2(NW);

    // det and adjugate of the coefficient matrix, fixed at elaboration
    localparam int DET   = -A*B*B + A*B*C + B*B*C - B*C*C;
    localparam int ADJ00 = B*A - A*B;
    localparam int ADJ01 = -(A*B - B*C);
    localparam int ADJ02 = A*B - B*C;
    localparam int ADJ10 = -(B*A - A*C);
    localparam int ADJ11 = A*A - C*C;
    localparam int ADJ12 = -(A*A - B*C);
    localparam int ADJ20 = B*B - B*C;
    localparam int ADJ21 = -(A*B - B*C);
    localparam int ADJ22 = A*B - B*B;

    localparam int          DET_ABS = (DET < 0) ? -DET : DET;
    localparam logic        DET_NEG = 1'(DET < 0);
    localparam logic [RW-1:0] DVS   = RW'(DET_ABS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CALC  = 2'd1;
    localparam logic [1:0] ST_DIV   = 2'd2;
`ifdef MATINV_CHECK_EN
    localparam logic [1:0] ST_CHECK = 2'd3;
`endif

    function automatic logic signed [SW-1:0] dot3(input int k0, input int k1, input int k2,
                                                  input logic [MW-1:0] m0, input logic [MW-1:0] m1,
                                                  input logic [MW-1:0] m2);
        return SW'(k0 * int'(m0) + k1 * int'(m1) + k2 * int'(m2));
    endfunction

    function automatic logic [NW-1:0] mag(input logic signed [SW-1:0] n);
        return NW'(n[SW-1] ? -n : n);
    endfunction

    logic [1:0]      state_q, state_d;
    logic [MW-1:0]   mo0_q, mo1_q, mo2_q;
    logic [NW-1:0]   dvd_q, mag1_q, mag2_q;
    logic [2:0]      neg_q;
    logic [NW-1:0]   rem_q, quo_q;
    logic [STW-1:0]  step_q;
    logic [1:0]      row_q;
    logic [3*DW-1:0] res_q;
    logic [2:0]      rex_q;
    logic            out_valid_q, exact_q, busy_q;
    logic [DW-1:0]   di0_q, di1_q, di2_q;

    logic                 accept_c, done_c, last_step_c, exact_d_c;
    logic signed [SW-1:0] n0_c, n1_c, n2_c;
    logic [RW-1:0]        shl_c;
    logic                 ge_c;
    logic [NW-1:0]        rem_n_c, quo_n_c;
    logic [DW-1:0]        val_c;
    logic                 rex_c;

    assign bus.in_ready = (state_q == ST_IDLE) && !rst;
    assign accept_c     = bus.in_valid && bus.in_ready;

    assign n0_c = dot3(ADJ00, ADJ01, ADJ02, mo0_q, mo1_q, mo2_q);
    assign n1_c = dot3(ADJ10, ADJ11, ADJ12, mo0_q, mo1_q, mo2_q);
    assign n2_c = dot3(ADJ20, ADJ21, ADJ22, mo0_q, mo1_q, mo2_q);

    // One restoring step: shift in the next dividend bit, subtract when it fits
    assign shl_c       = {rem_q, dvd_q[NW-1]};
    assign ge_c        = shl_c >= DVS;
    assign rem_n_c     = ge_c ? NW'(shl_c - DVS) : NW'(shl_c);
    assign quo_n_c     = NW'({quo_q, ge_c});
    assign last_step_c = step_q == STW'(NW - 1);

    // Row result clamping; neg_q[0] is the sign of the row being divided
    always_comb begin
        val_c = quo_n_c[DW-1:0];
        rex_c = (rem_n_c == '0);
        if (neg_q[0] && (quo_n_c != '0)) begin
            val_c = '0;
            rex_c = 1'b0;
        end else if (quo_n_c[NW-1:DW] != '0) begin
            val_c = '1;
            rex_c = 1'b0;
        end
    end

`ifdef MATINV_CHECK_EN
    function automatic int fwd3(input int k0, input int k1, input int k2,
                                input logic [DW-1:0] v0, input logic [DW-1:0] v1,
                                input logic [DW-1:0] v2);
        return k0 * int'(v0) + k1 * int'(v1) + k2 * int'(v2);
    endfunction

    logic chk_ok_c;
    assign chk_ok_c =
        (fwd3(A, B, C, res_q[DW-1:0], res_q[2*DW-1:DW], res_q[3*DW-1:2*DW]) == int'(mo0_q)) &&
        (fwd3(B, B, A, res_q[DW-1:0], res_q[2*DW-1:DW], res_q[3*DW-1:2*DW]) == int'(mo1_q)) &&
        (fwd3(C, B, A, res_q[DW-1:0], res_q[2*DW-1:DW], res_q[3*DW-1:2*DW]) == int'(mo2_q));
    assign done_c    = (state_q == ST_CHECK);
    assign exact_d_c = (&rex_q) && chk_ok_c;
`else
    assign done_c    = (state_q == ST_DIV) && (row_q == 2'd3);
    assign exact_d_c = &rex_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_c) state_d = ST_CALC;
            ST_CALC: state_d = ST_DIV;
            ST_DIV: begin
                if (row_q == 2'd3) begin
`ifdef MATINV_CHECK_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: capture, numerator setup, serial divide over rows 0..2, result publish
    always_ff @(posedge clk) begin
        if (rst) begin
            mo0_q <= '0; mo1_q <= '0; mo2_q <= '0;
            dvd_q <= '0; mag1_q <= '0; mag2_q <= '0;
            neg_q <= '0; rem_q <= '0; quo_q <= '0;
            step_q <= '0; row_q <= '0; res_q <= '0; rex_q <= '0;
            out_valid_q <= 1'b0; exact_q <= 1'b0; busy_q <= 1'b0;
            di0_q <= '0; di1_q <= '0; di2_q <= '0;
        end else begin
            out_valid_q <= done_c;
            busy_q      <= (state_d != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        mo0_q <= bus.mo0;
                        mo1_q <= bus.mo1;
                        mo2_q <= bus.mo2;
                    end
                end
                ST_CALC: begin
                    neg_q  <= {n2_c[SW-1], n1_c[SW-1], n0_c[SW-1]} ^ {3{DET_NEG}};
                    dvd_q  <= mag(n0_c);
                    mag1_q <= mag(n1_c);
                    mag2_q <= mag(n2_c);
                    rem_q  <= '0;
                    quo_q  <= '0;
                    step_q <= '0;
                    row_q  <= '0;
                end
                ST_DIV: begin
                    if (row_q != 2'd3) begin
                        if (last_step_c) begin
                            res_q  <= {val_c, res_q[3*DW-1:DW]};
                            rex_q  <= {rex_c, rex_q[2:1]};
                            neg_q  <= {1'b0, neg_q[2:1]};
                            dvd_q  <= mag1_q;
                            mag1_q <= mag2_q;
                            mag2_q <= '0;
                            rem_q  <= '0;
                            quo_q  <= '0;
                            step_q <= '0;
                            row_q  <= row_q + 2'd1;
                        end else begin
                            rem_q  <= rem_n_c;
                            quo_q  <= quo_n_c;
                            dvd_q  <= {dvd_q[NW-2:0], 1'b0};
                            step_q <= step_q + STW'(1);
                        end
                    end
                end
                default: ;
            endcase
            if (done_c) begin
                di0_q   <= res_q[DW-1:0];
                di1_q   <= res_q[2*DW-1:DW];
                di2_q   <= res_q[3*DW-1:2*DW];
                exact_q <= exact_d_c;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.di0       = di0_q;
    assign bus.di1       = di1_q;
    assign bus.di2       = di2_q;
    assign bus.exact     = exact_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_matrix_inv.sv
// Self-checking bench for matrix_inv: directed, random-vector and streaming scenarios against an integer model.
module tb_matrix_inv;
`ifdef MATINV_CHECK_EN
    localparam int LAT = 63;
`else
    localparam int LAT = 62;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    matrix_inv_if bus ();

    matrix_inv dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Exact rational inverse: di_k = (adj_k . mo) / det, truncated, then range/sign clamped
    function automatic void model(input int m0, input int m1, input int m2,
                                  output logic [11:0] d, output logic ex);
        int adj [3][3];
        int v [3];
        int n, q, r;
        adj = '{'{0, -26, 26}, '{-56, 24, 16}, '{104, -26, -78}};
        ex = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n = adj[k][0] * m0 + adj[k][1] * m1 + adj[k][2] * m2;
            q = n / -208;
            r = n % -208;
            if (r != 0) ex = 1'b0;
            if (q < 0) begin
                v[k] = 0;
                ex = 1'b0;
            end else if (q > 15) begin
                v[k] = 15;
                ex = 1'b0;
            end else begin
                v[k] = q;
            end
        end
`ifdef MATINV_CHECK_EN
        if (7*v[0] + 13*v[1] + 5*v[2] != m0 || 13*v[0] + 13*v[1] + 7*v[2] != m1 ||
            5*v[0] + 13*v[1] + 7*v[2] != m2) ex = 1'b0;
`endif
        d = {4'(v[0]), 4'(v[1]), 4'(v[2])};
    endfunction

    task automatic run_vec(input int m0, input int m1, input int m2, input string tag);
        logic [11:0] ed;
        logic        eex;
        int          lat;
        bit          seen;
        bit          busy_bad;
        model(m0, m1, m2, ed, eex);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.mo0 = 10'(m0);
        bus.mo1 = 10'(m1);
        bus.mo2 = 10'(m2);
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s ready_before got %b want 1", tag, bus.in_ready);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        seen = 1'b0;
        busy_bad = 1'b0;
        while (!seen && lat < LAT + 20) begin
            @(posedge clk);
            #1 lat++;
            if (bus.out_valid === 1'b1) seen = 1'b1;
            else if (lat < LAT && bus.busy !== 1'b1) busy_bad = 1'b1;
        end
        n_cmp++;
        if (!seen || lat != LAT) begin
            n_err++;
            $display("FAIL %s latency got %0d (seen=%0b) want %0d", tag, lat, seen, LAT);
        end
        n_cmp++;
        if (busy_bad) begin
            n_err++;
            $display("FAIL %s busy_during got low want high", tag);
        end
        n_cmp++;
        if ({bus.di0, bus.di1, bus.di2, bus.exact} !== {ed, eex}) begin
            n_err++;
            $display("FAIL %s result got di=(%0d,%0d,%0d) exact=%b want di=(%0d,%0d,%0d) exact=%b",
                     tag, bus.di0, bus.di1, bus.di2, bus.exact, ed[11:8], ed[7:4], ed[3:0], eex);
        end
        n_cmp++;
        if ({bus.in_ready, bus.busy} !== 2'b10) begin
            n_err++;
            $display("FAIL %s done_flags got ready=%b busy=%b want ready=1 busy=0", tag, bus.in_ready, bus.busy);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s pulse_width got out_valid=%b want 0", tag, bus.out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.mo0 = '0; bus.mo1 = '0; bus.mo2 = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.out_valid, bus.di0, bus.di1, bus.di2, bus.exact, bus.busy, bus.in_ready} !== 16'h0) begin
            n_err++;
            $display("FAIL reset_state got ov=%b di=(%0d,%0d,%0d) ex=%b busy=%b rdy=%b want all 0",
                     bus.out_valid, bus.di0, bus.di1, bus.di2, bus.exact, bus.busy, bus.in_ready);
        end
        // rst and in_valid together: nothing captured
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.mo0 = 10'd7; bus.mo1 = 10'd13; bus.mo2 = 10'd5;
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy, bus.in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL reset_wins got busy=%b ready=%b want busy=0 ready=1", bus.busy, bus.in_ready);
        end
    endtask

    task automatic test_directed();
        run_vec(7, 13, 5, "unit");
        run_vec(375, 495, 375, "max");
        run_vec(0, 0, 0, "zero");
        run_vec(1, 0, 0, "inexact");
    endtask

    task automatic test_random_mo();
        for (int i = 0; i < 12; i++)
            run_vec(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                    int'($urandom_range(0, 1023)), "rand_mo");
    endtask

    task automatic test_reset_mid();
        bit ov_seen;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.mo0 = 10'd7; bus.mo1 = 10'd13; bus.mo2 = 10'd5;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (29) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.out_valid, bus.di0, bus.di1, bus.di2, bus.exact, bus.busy, bus.in_ready} !== 16'h0) begin
            n_err++;
            $display("FAIL midreset_state got ov=%b di=(%0d,%0d,%0d) ex=%b busy=%b rdy=%b want all 0",
                     bus.out_valid, bus.di0, bus.di1, bus.di2, bus.exact, bus.busy, bus.in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_ready got %b want 1", bus.in_ready);
        end
        ov_seen = 1'b0;
        repeat (60) begin
            @(posedge clk);
            #1 if (bus.out_valid !== 1'b0) ov_seen = 1'b1;
        end
        n_cmp++;
        if (ov_seen) begin
            n_err++;
            $display("FAIL midreset_no_output got out_valid pulse want none");
        end
        run_vec(375, 495, 375, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [11:0] expq [$];
        logic [11:0] src;
        logic [3:0]  d0, d1, d2;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int extra = 0;
        int bad = 0;
        bus.in_valid = 1'b1;
        while (got < 100 && cyc < 8000) begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid === 1'b1) begin
                if (expq.size() == 0) begin
                    extra++;
                end else begin
                    src = expq.pop_front();
                    got++;
                    n_cmp++;
                    if ({bus.di0, bus.di1, bus.di2, bus.exact} !== {src, 1'b1}) begin
                        n_err++;
                        bad++;
                        if (bad < 10)
                            $display("FAIL stream_result #%0d got di=(%0d,%0d,%0d) exact=%b want di=(%0d,%0d,%0d) exact=1",
                                     got, bus.di0, bus.di1, bus.di2, bus.exact, src[11:8], src[7:4], src[3:0]);
                    end
                end
            end
            if (bus.in_ready === 1'b1 && sent < 100) begin
                d0 = 4'($urandom_range(0, 15));
                d1 = 4'($urandom_range(0, 15));
                d2 = 4'($urandom_range(0, 15));
                bus.mo0 = 10'(7*int'(d0) + 13*int'(d1) + 5*int'(d2));
                bus.mo1 = 10'(13*int'(d0) + 13*int'(d1) + 7*int'(d2));
                bus.mo2 = 10'(5*int'(d0) + 13*int'(d1) + 7*int'(d2));
                expq.push_back({d0, d1, d2});
                sent++;
            end else if (bus.in_ready === 1'b1) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.mo0 = 10'($urandom_range(0, 1023));
                bus.mo1 = 10'($urandom_range(0, 1023));
                bus.mo2 = 10'($urandom_range(0, 1023));
            end
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (got != 100) begin
            n_err++;
            $display("FAIL stream_count got %0d results want 100 (cycles %0d)", got, cyc);
        end
        repeat (100) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_err++;
            $display("FAIL stream_extra got %0d extra out_valid pulses want 0", extra);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random_mo();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
